accum_mult_mod_sqr_ctrl: RTL and testbench

Sequencing controller for the accumulating modular multiplier. It loads the multiplier's reduction RAM from a host word stream. It then runs repeated modular squaring (x → x² mod N, T times), the VDF inner loop, by driving the multiplier's valid/ready ports and feeding each result back as the next operand. It sits between the host/command interface and one `accum_mult_mod` instance and owns all of that instance's input ports.

---
 rtl/accum_mult_mod_sqr_ctrl_if.sv | 50 +++++
 rtl/accum_mult_mod_sqr_ctrl.sv | 167 ++++++++++++++++
 tb/tb_accum_mult_mod_sqr_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_mult_mod_sqr_ctrl_if.sv
// Bundle of host, multiplier and reduction-RAM signals for the squaring
// controller. Signal names keep the i_/o_ prefix of the controller's view.
//   slave  : the controller (drives every o_* signal)
//   master : host + multiplier + RAM side (drives every i_* signal)
// Groups: cfg word stream (i_cfg_*/o_cfg_rdy), command (i_val/o_rdy/i_dat/
// i_iter), result (o_val/i_rdy/o_dat), status (o_cfg_ok/o_busy),
// multiplier operands/results (o_mul_*/i_mul_*), RAM write port (o_ram_*).
interface accum_mult_mod_sqr_ctrl_if #(
  parameter int unsigned BITS    = 382,
  parameter int unsigned RAM_D_W = 32,
  parameter int unsigned ITER_W  = 40
);
  logic               i_cfg_val;
  logic               o_cfg_rdy;
  logic [RAM_D_W-1:0] i_cfg_d;
  logic               i_cfg_last;
  logic               i_val;
  logic               o_rdy;
  logic [BITS-1:0]    i_dat;
  logic [ITER_W-1:0]  i_iter;
  logic               o_val;
  logic               i_rdy;
  logic [BITS-1:0]    o_dat;
  logic               o_cfg_ok;
  logic               o_busy;
  logic               o_mul_val;
  logic               i_mul_rdy;
  logic [BITS-1:0]    o_mul_dat_a;
  logic [BITS-1:0]    o_mul_dat_b;
  logic               i_mul_val;
  logic               o_mul_rdy;
  logic [BITS-1:0]    i_mul_dat;
  logic [RAM_D_W-1:0] o_ram_d;
  logic               o_ram_we;
  logic               o_ram_se;

  modport slave (
    input  i_cfg_val, i_cfg_d, i_cfg_last, i_val, i_dat, i_iter, i_rdy,
           i_mul_rdy, i_mul_val, i_mul_dat,
    output o_cfg_rdy, o_rdy, o_val, o_dat, o_cfg_ok, o_busy, o_mul_val,
           o_mul_dat_a, o_mul_dat_b, o_mul_rdy, o_ram_d, o_ram_we, o_ram_se
  );

  modport master (
    output i_cfg_val, i_cfg_d, i_cfg_last, i_val, i_dat, i_iter, i_rdy,
           i_mul_rdy, i_mul_val, i_mul_dat,
    input  o_cfg_rdy, o_rdy, o_val, o_dat, o_cfg_ok, o_busy, o_mul_val,
           o_mul_dat_a, o_mul_dat_b, o_mul_rdy, o_ram_d, o_ram_we, o_ram_se
  );
endinterface

// File: rtl/accum_mult_mod_sqr_ctrl.sv
// Sequencing controller for one accum_mult_mod instance.
// Loads the reduction RAM from a host word stream, then runs T modular
// squarings (x -> x^2 mod N) by feeding each multiplier result back as the
// next operand pair. One multiplication is in flight at a time.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (aborts any operation, clears
//            o_cfg_ok so the table must be reloaded)
//   bus    : controller side of accum_mult_mod_sqr_ctrl_if (config stream,
//            command, result, status, multiplier and RAM ports)
module accum_mult_mod_sqr_ctrl #(
  parameter int unsigned BITS    = 382,
  parameter int unsigned RAM_A_W = 8,
  parameter int unsigned RAM_D_W = 32,
  parameter int unsigned ITER_W  = 40
) (
  input logic                      i_clk,
  input logic                      i_rst,
  accum_mult_mod_sqr_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_e;

  state_e             state_q;
  logic [BITS-1:0]    cur_q;
  logic [ITER_W-1:0]  cnt_q;
  logic [RAM_A_W-1:0] wcnt_q;
  logic               commit_q;
  logic               cfg_ok_q;
  logic               cfg_rdy_q;
  logic               mul_val_q;
  logic               mul_rdy_q;
  logic               val_q;
  logic               busy_q;
  logic               ram_we_q;
  logic               ram_se_q;
  logic [RAM_D_W-1:0] ram_d_q;

  logic               rdy;
  logic               cfg_hs;
  logic               cmd_hs;
  logic [RAM_A_W-1:0] word_idx;
  logic               word_last;

  // Config has priority over a command presented in the same IDLE cycle.
  assign rdy    = (state_q == IDLE) && cfg_ok_q && !bus.i_cfg_val;
  assign cfg_hs = bus.i_cfg_val && cfg_rdy_q;
  assign cmd_hs = bus.i_val && rdy;

  // The word taken in IDLE is word 0; the last addressable word is forced last.
  assign word_idx  = (state_q == IDLE) ? '0 : wcnt_q;
  assign word_last = bus.i_cfg_last || (word_idx == '1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      commit_q  <= 1'b0;
      cfg_ok_q  <= 1'b0;
      cfg_rdy_q <= 1'b1;
      mul_val_q <= 1'b0;
      mul_rdy_q <= 1'b1;
      val_q     <= 1'b0;
      busy_q    <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_se_q  <= 1'b0;
      ram_d_q   <= '0;
    end else begin
      ram_we_q <= 1'b0;
      ram_se_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_hs) begin
            state_q   <= LOAD;
            busy_q    <= 1'b1;
            cfg_ok_q  <= 1'b0;
            ram_d_q   <= bus.i_cfg_d;
            ram_we_q  <= 1'b1;
            wcnt_q    <= RAM_A_W'(1);
            commit_q  <= word_last;
            cfg_rdy_q <= !word_last;
          end else if (cmd_hs) begin
            cur_q     <= bus.i_dat;
            cnt_q     <= bus.i_iter;
            busy_q    <= 1'b1;
            cfg_rdy_q <= 1'b0;
            mul_rdy_q <= 1'b0;
            if (bus.i_iter == '0) begin
              state_q <= DONE;
              val_q   <= 1'b1;
            end else begin
              state_q   <= ISSUE;
              mul_val_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          // commit_q marks the cycle after the final write: strobe the commit
          // and leave. Results still draining from an aborted run are
          // accepted and dropped here as in IDLE.
          if (commit_q) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            ram_se_q  <= 1'b1;
            cfg_ok_q  <= 1'b1;
            cfg_rdy_q <= 1'b1;
            commit_q  <= 1'b0;
          end else if (cfg_hs) begin
            ram_d_q   <= bus.i_cfg_d;
            ram_we_q  <= 1'b1;
            wcnt_q    <= wcnt_q + RAM_A_W'(1);
            commit_q  <= word_last;
            cfg_rdy_q <= !word_last;
          end
        end
        ISSUE: begin
          if (bus.i_mul_rdy) begin
            state_q   <= WAIT;
            mul_val_q <= 1'b0;
            mul_rdy_q <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.i_mul_val) begin
            cur_q     <= bus.i_mul_dat;
            cnt_q     <= cnt_q - ITER_W'(1);
            mul_rdy_q <= 1'b0;
            if (cnt_q == ITER_W'(1)) begin
              state_q <= DONE;
              val_q   <= 1'b1;
            end else begin
              state_q   <= ISSUE;
              mul_val_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.i_rdy) begin
            state_q   <= IDLE;
            val_q     <= 1'b0;
            busy_q    <= 1'b0;
            cfg_rdy_q <= 1'b1;
            mul_rdy_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_cfg_rdy   = cfg_rdy_q;
  assign bus.o_rdy       = rdy;
  assign bus.o_val       = val_q;
  assign bus.o_dat       = cur_q;
  assign bus.o_cfg_ok    = cfg_ok_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_mul_val   = mul_val_q;
  assign bus.o_mul_dat_a = cur_q;
  assign bus.o_mul_dat_b = cur_q;
  assign bus.o_mul_rdy   = mul_rdy_q;
  assign bus.o_ram_d     = ram_d_q;
  assign bus.o_ram_we    = ram_we_q;
  assign bus.o_ram_se    = ram_se_q;

endmodule

// File: tb/tb_accum_mult_mod_sqr_ctrl.sv
// Bench for accum_mult_mod_sqr_ctrl with a behavioural fixed-latency
// modular multiplier (mod 1000003) and a reduction RAM of 2^2 words.
module tb_accum_mult_mod_sqr_ctrl;
  localparam int unsigned BITS    = 382;
  localparam int unsigned RAM_A_W = 2;
  localparam int unsigned RAM_D_W = 32;
  localparam int unsigned ITER_W  = 40;
  localparam longint unsigned MODN = 1000003;
  localparam int LAT = 5;

  typedef logic [BITS-1:0] val_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accum_mult_mod_sqr_ctrl_if #(.BITS(BITS), .RAM_D_W(RAM_D_W), .ITER_W(ITER_W)) bus ();

  accum_mult_mod_sqr_ctrl #(
    .BITS(BITS), .RAM_A_W(RAM_A_W), .RAM_D_W(RAM_D_W), .ITER_W(ITER_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected result: x squared T times, mod N.
  function automatic longint unsigned sq_chain(input longint unsigned x, input int unsigned t);
    longint unsigned r = x % MODN;
    for (int unsigned i = 0; i < t; i++) r = (r * r) % MODN;
    return r;
  endfunction

  // Monitors and multiplier model (edge-sampled, drives #1 after the edge).
  int              cyc = 0;
  int              we_cyc[$];
  logic [RAM_D_W-1:0] we_dat[$];
  int              se_cyc[$];
  int              ok_rise = -1;
  logic            ok_prev = 1'b0;
  int              mul_hs = 0;
  bit              rand_rdy = 1'b1;
  bit              pend = 1'b0;
  int              due = 0;
  longint unsigned pres = 0;

  initial begin : mul_model
    longint unsigned a;
    bus.i_mul_rdy = 1'b0;
    bus.i_mul_val = 1'b0;
    bus.i_mul_dat = '0;
    forever begin
      @(posedge clk);
      if (bus.o_ram_we) begin
        we_cyc.push_back(cyc);
        we_dat.push_back(bus.o_ram_d);
      end
      if (bus.o_ram_se) se_cyc.push_back(cyc);
      if (bus.o_cfg_ok && !ok_prev) ok_rise = cyc;
      ok_prev = bus.o_cfg_ok;
      if (bus.o_mul_val && bus.i_mul_rdy) begin
        mul_hs++;
        check("mul_a_eq_b", bus.o_mul_dat_a, bus.o_mul_dat_b);
        a    = bus.o_mul_dat_a[63:0];
        pres = (a * a) % MODN;
        pend = 1'b1;
        due  = cyc + LAT;
      end
      if (bus.i_mul_val && bus.o_mul_rdy) pend = 1'b0;
      cyc++;
      #1;
      bus.i_mul_val = pend && (cyc >= due);
      bus.i_mul_dat = pend ? val_t'(pres) : '0;
      bus.i_mul_rdy = !pend && (!rand_rdy || ($urandom_range(0, 2) != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [RAM_D_W-1:0] wq[$];
  int                 hsq[$];

  task automatic load_table(input bit use_last);
    int guard;
    we_cyc.delete();
    we_dat.delete();
    se_cyc.delete();
    hsq.delete();
    ok_rise = -1;
    for (int i = 0; i < wq.size(); i++) begin
      bus.i_cfg_val  = 1'b1;
      bus.i_cfg_d    = wq[i];
      bus.i_cfg_last = use_last && (i == wq.size() - 1);
      guard = 0;
      while (!bus.o_cfg_rdy && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) begin
        check("cfg_rdy_timeout", 0, 1);
        break;
      end
      hsq.push_back(cyc);
      tick();
    end
    bus.i_cfg_val  = 1'b0;
    bus.i_cfg_last = 1'b0;
  endtask

  task automatic check_load();
    repeat (4) tick();
    check("we_count", val_t'(we_dat.size()), val_t'(wq.size()));
    for (int i = 0; i < wq.size() && i < we_dat.size() && i < hsq.size(); i++) begin
      check("we_data", val_t'(we_dat[i]), val_t'(wq[i]));
      check("we_cycle", val_t'(we_cyc[i]), val_t'(hsq[i] + 1));
    end
    check("se_count", val_t'(se_cyc.size()), 1);
    if (se_cyc.size() > 0 && hsq.size() > 0)
      check("se_cycle", val_t'(se_cyc[0]), val_t'(hsq[hsq.size()-1] + 2));
    if (hsq.size() > 0)
      check("cfg_ok_cycle", val_t'(ok_rise), val_t'(hsq[hsq.size()-1] + 2));
    check("cfg_ok_after_load", val_t'(bus.o_cfg_ok), 1);
    check("busy_after_load", val_t'(bus.o_busy), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_cfg_rdy", val_t'(bus.o_cfg_rdy), 1);
    check("rst_mul_rdy", val_t'(bus.o_mul_rdy), 1);
    check("rst_rdy", val_t'(bus.o_rdy), 0);
    check("rst_val", val_t'(bus.o_val), 0);
    check("rst_dat", bus.o_dat, '0);
    check("rst_cfg_ok", val_t'(bus.o_cfg_ok), 0);
    check("rst_busy", val_t'(bus.o_busy), 0);
    check("rst_mul_val", val_t'(bus.o_mul_val), 0);
    check("rst_mul_a", bus.o_mul_dat_a, '0);
    check("rst_ram_we", val_t'(bus.o_ram_we), 0);
    check("rst_ram_se", val_t'(bus.o_ram_se), 0);
    check("rst_ram_d", val_t'(bus.o_ram_d), '0);
  endtask

  task automatic send_cmd(input longint unsigned x, input longint unsigned t, output int c0);
    int guard = 0;
    bus.i_dat  = val_t'(x);
    bus.i_iter = ITER_W'(t);
    bus.i_val  = 1'b1;
    while (!bus.o_rdy && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("cmd_rdy_timeout", 0, 1);
    c0 = cyc;
    tick();
    bus.i_val = 1'b0;
  endtask

  task automatic run_cmd(input longint unsigned x, input int unsigned t,
                         input int hold, input bit fixed_lat);
    int c0, tv, guard, h0;
    longint unsigned exp;
    h0  = mul_hs;
    exp = sq_chain(x, t);
    send_cmd(x, t, c0);
    guard = 0;
    while (!bus.o_val && guard < 3000) begin
      tick();
      guard++;
    end
    if (guard >= 3000) begin
      check("result_timeout", 0, 1);
      return;
    end
    tv = cyc;
    check("result", bus.o_dat, val_t'(exp));
    check("mul_handshakes", val_t'(mul_hs - h0), val_t'(t));
    check("busy_in_done", val_t'(bus.o_busy), 1);
    if (t == 0) check("t0_latency", val_t'(tv), val_t'(c0 + 1));
    else if (fixed_lat) check("fixed_latency", val_t'(tv), val_t'(c0 + t * (LAT + 1) + 1));
    for (int i = 0; i < hold; i++) begin
      bus.i_val  = 1'b1;
      bus.i_dat  = val_t'(77);
      bus.i_iter = ITER_W'(1);
      #1;
      check("hold_no_cmd", val_t'(bus.o_rdy), 0);
      check("hold_val", val_t'(bus.o_val), 1);
      check("hold_dat", bus.o_dat, val_t'(exp));
      tick();
    end
    bus.i_val = 1'b0;
    bus.i_rdy = 1'b1;
    tick();
    bus.i_rdy = 1'b0;
    check("val_cleared", val_t'(bus.o_val), 0);
    check("idle_after_done", val_t'(bus.o_busy), 0);
    check("no_extra_mul", val_t'(mul_hs - h0), val_t'(t));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, guard, h0;
    bus.i_cfg_val  = 1'b0;
    bus.i_cfg_d    = '0;
    bus.i_cfg_last = 1'b0;
    bus.i_val      = 1'b0;
    bus.i_dat      = '0;
    bus.i_iter     = '0;
    bus.i_rdy      = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals();
    rst = 1'b0;
    tick();

    // Command before any table: never accepted, multiplier idle.
    bus.i_val  = 1'b1;
    bus.i_dat  = val_t'(5);
    bus.i_iter = ITER_W'(1);
    for (int i = 0; i < 5; i++) begin
      check("no_table_rdy", val_t'(bus.o_rdy), 0);
      tick();
      check("no_table_mul_val", val_t'(bus.o_mul_val), 0);
    end
    bus.i_val = 1'b0;
    check("no_table_mul_hs", val_t'(mul_hs), 0);

    // 4 words, last on the 4th.
    wq.delete();
    for (int i = 1; i <= 4; i++) wq.push_back(RAM_D_W'(32'h11 * i));
    load_table(1'b1);
    check_load();

    // 3-word table terminated by last.
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(RAM_D_W'($urandom));
    load_table(1'b1);
    check_load();

    // 4 words with no last: forced commit at the table size.
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(RAM_D_W'($urandom));
    load_table(1'b0);
    check_load();

    // Single-word table, then T=0.
    wq.delete();
    wq.push_back(RAM_D_W'(32'hA5));
    load_table(1'b1);
    check_load();
    run_cmd(3, 0, 0, 1'b0);

    // Random-ready multiplier.
    rand_rdy = 1'b1;
    run_cmd(2, 3, 0, 1'b0);
    run_cmd(2, 5, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_cmd(longint'($urandom_range(0, 1000002)), $urandom_range(1, 6), 0, 1'b0);

    // Always-ready multiplier: exact latency.
    rand_rdy = 1'b0;
    run_cmd(longint'($urandom_range(2, 1000002)), 4, 0, 1'b1);
    run_cmd(12345, 1, 0, 1'b1);

    // DONE held 10 cycles with a competing command.
    rand_rdy = 1'b1;
    run_cmd(longint'($urandom_range(2, 1000002)), 2, 10, 1'b0);

    // Config and command together in IDLE: config wins.
    h0 = mul_hs;
    we_dat.delete();
    bus.i_cfg_val  = 1'b1;
    bus.i_cfg_d    = RAM_D_W'(32'hAB);
    bus.i_cfg_last = 1'b1;
    bus.i_val      = 1'b1;
    bus.i_dat      = val_t'(9);
    bus.i_iter     = ITER_W'(1);
    #1;
    check("collide_rdy", val_t'(bus.o_rdy), 0);
    check("collide_cfg_rdy", val_t'(bus.o_cfg_rdy), 1);
    tick();
    bus.i_cfg_val  = 1'b0;
    bus.i_cfg_last = 1'b0;
    bus.i_val      = 1'b0;
    check("collide_busy", val_t'(bus.o_busy), 1);
    check("collide_cfg_ok", val_t'(bus.o_cfg_ok), 0);
    repeat (4) tick();
    check("collide_word", (we_dat.size() == 1) ? val_t'(we_dat[0]) : '0, val_t'(32'hAB));
    check("collide_no_mul", val_t'(mul_hs - h0), 0);
    check("collide_no_val", val_t'(bus.o_val), 0);
    check("collide_cfg_ok_after", val_t'(bus.o_cfg_ok), 1);

    // Reset while waiting on the multiplier during a long run.
    rand_rdy = 1'b0;
    h0 = mul_hs;
    send_cmd(7, 100, c0);
    guard = 0;
    while (mul_hs - h0 < 3 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("wait_reach_timeout", 0, 1);
    tick();
    tick();
    check("in_wait_busy", val_t'(bus.o_busy), 1);
    check("in_wait_mul_rdy", val_t'(bus.o_mul_rdy), 1);
    check("in_wait_pending", val_t'(pend), 1);
    rst = 1'b1;
    tick();
    check_reset_vals();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_val", val_t'(bus.o_val), 0);
      check("post_rst_mul_val", val_t'(bus.o_mul_val), 0);
    end
    check("late_result_drained", val_t'(pend), 0);
    check("post_rst_dat", bus.o_dat, '0);
    check("post_rst_cfg_ok", val_t'(bus.o_cfg_ok), 0);
    wq.delete();
    wq.push_back(RAM_D_W'(32'h1));
    wq.push_back(RAM_D_W'(32'h2));
    load_table(1'b1);
    check_load();
    run_cmd(5, 2, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
